id_inst_queue: RTL and testbench

Parametrised instruction queue between IF and ID. It replaces the single-entry `flag`/`buf_inst` capture with a DEPTH-entry first-word-fall-through FIFO of {pc, inst} pairs, so ID stalls of any length lose no fetched instruction. Branch resolution in ID can flush the queue and optionally keep one delay-slot entry. ID consumes the head; IF pushes when `in_ready` is high.

---
 rtl/id_pkg.sv | 19 +
 rtl/id_inst_queue.sv | 111 +++++++++++
 tb/tb_id_inst_queue.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | id_pkg : shared IF/ID defaults, NOP encoding and entry type       |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package id_pkg;

    localparam int PC_W_DEF   = 32;
    localparam int INST_W_DEF = 32;

    localparam logic [INST_W_DEF-1:0] NOP_INST = 32'b0;

    typedef struct packed {
        logic [PC_W_DEF-1:0]   pc;
        logic [INST_W_DEF-1:0] inst;
    } if_id_entry_t;

endpackage
`default_nettype wire

// File: rtl/id_inst_queue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | id_inst_queue : FWFT {pc, inst} queue between IF and ID with      |
// |                 branch flush and optional delay-slot retention    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module id_inst_queue
    import id_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int PC_W   = PC_W_DEF,
    parameter int INST_W = INST_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [PC_W-1:0]            in_pc,
    input  logic [INST_W-1:0]          in_inst,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [PC_W-1:0]            out_pc,
    output logic [INST_W-1:0]          out_inst,
    input  logic                       out_ready,
    input  logic                       flush,
    input  logic                       flush_keep1,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] occ;

    logic [AW-1:0] head_n;
    logic [AW-1:0] tail_n;
    logic [CW-1:0] occ_n;
    logic          push;
    logic          pop;

    assign in_ready  = (occ < CW'(DEPTH));
    assign out_valid = (occ != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = occ;

    assign out_pc   = out_valid ? mem[head].pc   : '0;
    assign out_inst = out_valid ? mem[head].inst : INST_W'(NOP_INST);

    // On a keep-one flush the survivor stays where it already lives in the
    // array; only the pointers collapse around it.
    always_comb begin
        head_n = head;
        tail_n = tail;
        occ_n  = occ;
        if (flush) begin
            if (flush_keep1 && pop && (occ >= CW'(2))) begin
                head_n = head + AW'(1);
                tail_n = head + AW'(2);
                occ_n  = CW'(1);
            end else if (flush_keep1 && !pop && (occ != '0)) begin
                tail_n = head + AW'(1);
                occ_n  = CW'(1);
            end else if (flush_keep1 && push) begin
                head_n = tail;
                tail_n = tail + AW'(1);
                occ_n  = CW'(1);
            end else begin
                head_n = tail;
                occ_n  = '0;
            end
        end else begin
            if (push) tail_n = tail + AW'(1);
            if (pop)  head_n = head + AW'(1);
            case ({push, pop})
                2'b10:   occ_n = occ + CW'(1);
                2'b01:   occ_n = occ - CW'(1);
                default: occ_n = occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            head <= head_n;
            tail <= tail_n;
            occ  <= occ_n;
        end
    end

    // Tail never aliases a live entry while push is allowed, so an
    // unconditional write on push cannot corrupt a flush survivor.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[tail] <= '{pc: in_pc, inst: in_inst};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_inst_queue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_id_inst_queue : directed self-checking bench for id_inst_queue |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_id_inst_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;
    logic        flush;
    logic        flush_keep1;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    id_inst_queue #(.DEPTH(4), .PC_W(32), .INST_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_pc       (in_pc),
        .in_inst     (in_inst),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .out_ready   (out_ready),
        .flush       (flush),
        .flush_keep1 (flush_keep1),
        .count       (count)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; flush_keep1 = 1'b0;
    endtask

    task automatic push_one(input logic [31:0] pc);
        in_valid = 1'b1; in_pc = pc; in_inst = pc ^ 32'hA5A5_0000;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); in_pc = '0; in_inst = '0;
        step(); step();
        rst = 1'b0;
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ctrl: count=%0d out_valid=%b in_ready=%b, want 0/0/1", count, out_valid, in_ready);
        end
        n_checks++;
        if (out_pc !== 32'h0 || out_inst !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: out_pc=%h out_inst=%h, want 0/0", out_pc, out_inst);
        end
    endtask

    task automatic test_fill_drain();
        idle();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_pc = 32'h100 + 32'(4*i); in_inst = 32'hA000_0000 + 32'(i);
            step();
            n_checks++;
            if (count !== 3'(i+1) || out_pc !== 32'h100) begin
                n_fail++;
                $display("FAIL fill_%0d: count=%0d out_pc=%h, want %0d/100", i, count, out_pc, i+1);
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0 || count !== 3'd4) begin
            n_fail++;
            $display("FAIL full_state: in_ready=%b count=%0d, want 0/4", in_ready, count);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'h100 + 32'(4*i) || out_inst !== 32'hA000_0000 + 32'(i)) begin
                n_fail++;
                $display("FAIL drain_%0d: valid=%b pc=%h inst=%h, want 1/%h/%h", i, out_valid, out_pc, out_inst,
                         32'h100 + 32'(4*i), 32'hA000_0000 + 32'(i));
            end
            step();
        end
        n_checks++;
        if (out_valid !== 1'b0 || out_inst !== 32'h0 || count !== 3'd0) begin
            n_fail++;
            $display("FAIL drained: valid=%b inst=%h count=%0d, want 0/0/0", out_valid, out_inst, count);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        idle();
        // Move head and tail to 3 before the interleaved run.
        for (int i = 0; i < 3; i++) push_one(32'h380 + 32'(4*i));
        out_ready = 1'b1;
        step(); step(); step();
        out_ready = 1'b0;
        n_checks++;
        if (count !== 3'd0 || dut.head !== 2'd3) begin
            n_fail++;
            $display("FAIL wrap_setup: count=%0d head=%0d, want 0/3", count, dut.head);
        end
        for (int c = 0; c < 7; c++) begin
            in_valid = (c < 6); in_pc = 32'h400 + 32'(4*c); in_inst = 32'hB000_0000 + 32'(c);
            out_ready = (c > 0);
            if (c > 0) begin
                n_checks++;
                if (out_pc !== 32'h400 + 32'(4*(c-1)) || out_inst !== 32'hB000_0000 + 32'(c-1) || count !== 3'd1) begin
                    n_fail++;
                    $display("FAIL wrap_%0d: pc=%h inst=%h count=%0d, want %h/%h/1", c, out_pc, out_inst, count,
                             32'h400 + 32'(4*(c-1)), 32'hB000_0000 + 32'(c-1));
                end
            end
            step();
        end
        idle();
        n_checks++;
        if (count !== 3'd0 || dut.tail !== 2'd1) begin
            n_fail++;
            $display("FAIL wrap_end: count=%0d tail=%0d, want 0/1", count, dut.tail);
        end
    endtask

    task automatic test_full_pop();
        idle();
        for (int i = 0; i < 4; i++) push_one(32'h500 + 32'(4*i));
        in_valid = 1'b1; in_pc = 32'h600; in_inst = 32'h6666_6666; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n_checks++;
        if (count !== 3'd3 || in_ready !== 1'b1 || out_pc !== 32'h504) begin
            n_fail++;
            $display("FAIL full_pop: count=%0d in_ready=%b pc=%h, want 3/1/504", count, in_ready, out_pc);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (out_pc !== 32'h504 + 32'(4*i)) begin
                n_fail++;
                $display("FAIL full_pop_drain_%0d: pc=%h, want %h", i, out_pc, 32'h504 + 32'(4*i));
            end
            step();
        end
        n_checks++;
        if (count !== 3'd0) begin
            n_fail++;
            $display("FAIL full_pop_rejected: count=%0d, want 0", count);
        end
        idle();
    endtask

    task automatic test_flush();
        idle();
        for (int i = 0; i < 3; i++) push_one(32'h700 + 32'(4*i));
        in_valid = 1'b1; in_pc = 32'h7F0; in_inst = 32'h7777_7777; flush = 1'b1;
        step();
        idle();
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_inst !== 32'h0) begin
            n_fail++;
            $display("FAIL flush: count=%0d valid=%b inst=%h, want 0/0/0", count, out_valid, out_inst);
        end
        step();
        n_checks++;
        if (count !== 3'd0) begin
            n_fail++;
            $display("FAIL flush_push_dropped: count=%0d, want 0", count);
        end
    endtask

    task automatic test_flush_keep1();
        idle();
        for (int i = 0; i < 3; i++) push_one(32'h200 + 32'(4*i));
        out_ready = 1'b1; flush = 1'b1; flush_keep1 = 1'b1;
        step();
        idle();
        n_checks++;
        if (count !== 3'd1 || out_pc !== 32'h204 || out_inst !== (32'h204 ^ 32'hA5A5_0000)) begin
            n_fail++;
            $display("FAIL keep1_pop: count=%0d pc=%h inst=%h, want 1/204/%h", count, out_pc, out_inst, 32'h204 ^ 32'hA5A5_0000);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++;
        if (count !== 3'd0) begin
            n_fail++;
            $display("FAIL keep1_pop_drain: count=%0d, want 0", count);
        end
        in_valid = 1'b1; in_pc = 32'h300; in_inst = 32'h3333_0000; flush = 1'b1; flush_keep1 = 1'b1;
        step();
        idle();
        n_checks++;
        if (count !== 3'd1 || out_pc !== 32'h300 || out_inst !== 32'h3333_0000) begin
            n_fail++;
            $display("FAIL keep1_push: count=%0d pc=%h inst=%h, want 1/300/33330000", count, out_pc, out_inst);
        end
        out_ready = 1'b1;
        step();
        idle();
        // No pop: head survives and the same-cycle push is dropped.
        push_one(32'h220); push_one(32'h224);
        in_valid = 1'b1; in_pc = 32'h228; in_inst = 32'h2828_2828; flush = 1'b1; flush_keep1 = 1'b1;
        step();
        idle();
        n_checks++;
        if (count !== 3'd1 || out_pc !== 32'h220) begin
            n_fail++;
            $display("FAIL keep1_nopop: count=%0d pc=%h, want 1/220", count, out_pc);
        end
        out_ready = 1'b1;
        step();
        idle();
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL keep1_nopop_drain: count=%0d valid=%b, want 0/0", count, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        idle();
        push_one(32'h900); push_one(32'h904);
        rst = 1'b1; in_valid = 1'b1; in_pc = 32'h908; flush = 1'b1; out_ready = 1'b1;
        step();
        rst = 1'b0;
        idle();
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: count=%0d valid=%b in_ready=%b, want 0/0/1", count, out_valid, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_pop();
        test_flush();
        test_flush_keep1();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
